// File: rtl/note_tone_gen_pkg.sv
// Shared constants and types for the note tone generator: note codes,
// mid-octave frequencies, octave selects and the FSM state encoding.
package note_tone_gen_pkg;

    localparam int PERIOD_W = 24;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    localparam int unsigned FREQ_DO  = 262;
    localparam int unsigned FREQ_RE  = 294;
    localparam int unsigned FREQ_MI  = 330;
    localparam int unsigned FREQ_FA  = 349;
    localparam int unsigned FREQ_SOL = 392;
    localparam int unsigned FREQ_LA  = 440;
    localparam int unsigned FREQ_SI  = 494;

    localparam logic [1:0] OCT_LOW     = 2'd0;
    localparam logic [1:0] OCT_MID     = 2'd1;
    localparam logic [1:0] OCT_HIGH    = 2'd2;
    localparam logic [1:0] OCT_MID_ALT = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Codes 8..15 are not notes; the key controller may emit them and they mean silence.
    function automatic logic [3:0] map_note(input logic [3:0] raw);
        return raw[3] ? NOTE_NONE : raw;
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Combinational half-period lookup: note code and octave select to a
// half-period in clk cycles, derived from CLK_HZ at elaboration.
module note_period_rom
    import note_tone_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic [3:0]          note,
    input  logic [1:0]          octave,
    output logic [PERIOD_W-1:0] half_period
);

    localparam logic [PERIOD_W-1:0] HP_DO  = PERIOD_W'(CLK_HZ / (2 * FREQ_DO));
    localparam logic [PERIOD_W-1:0] HP_RE  = PERIOD_W'(CLK_HZ / (2 * FREQ_RE));
    localparam logic [PERIOD_W-1:0] HP_MI  = PERIOD_W'(CLK_HZ / (2 * FREQ_MI));
    localparam logic [PERIOD_W-1:0] HP_FA  = PERIOD_W'(CLK_HZ / (2 * FREQ_FA));
    localparam logic [PERIOD_W-1:0] HP_SOL = PERIOD_W'(CLK_HZ / (2 * FREQ_SOL));
    localparam logic [PERIOD_W-1:0] HP_LA  = PERIOD_W'(CLK_HZ / (2 * FREQ_LA));
    localparam logic [PERIOD_W-1:0] HP_SI  = PERIOD_W'(CLK_HZ / (2 * FREQ_SI));

    logic [PERIOD_W-1:0] hp_mid;

    always_comb begin
        hp_mid = '0;
        case (note)
            NOTE_DO:  hp_mid = HP_DO;
            NOTE_RE:  hp_mid = HP_RE;
            NOTE_MI:  hp_mid = HP_MI;
            NOTE_FA:  hp_mid = HP_FA;
            NOTE_SOL: hp_mid = HP_SOL;
            NOTE_LA:  hp_mid = HP_LA;
            NOTE_SI:  hp_mid = HP_SI;
            default:  hp_mid = '0;
        endcase
    end

    always_comb begin
        half_period = hp_mid;
        case (octave)
            OCT_LOW:  half_period = hp_mid << 1;
            OCT_HIGH: half_period = hp_mid >> 1;
            default:  half_period = hp_mid;
        endcase
    end

endmodule

// File: rtl/note_tone_gen.sv
// Buzzer tone generator: debounces the note code, then plays a square wave
// whose half-period only changes on a half-period boundary.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | silent, speaker held 0, waiting for a nonzero accepted note
//   ST_PLAY | toggling speaker every half-period of (cur_note, octave)
module note_tone_gen
    import note_tone_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned STABLE_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] note_in,
    input  logic [1:0] octave,
    output logic       speaker,
    output logic       playing,
    output logic [3:0] note_now
);

    localparam int STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);

    logic [3:0]          sample_d;
    logic [3:0]          sample;
    logic [3:0]          cur_note;
    logic [STAB_W-1:0]   stab_cnt;
    logic [PERIOD_W-1:0] half_period;
    logic [PERIOD_W-1:0] hp_cnt;
    logic [PERIOD_W-1:0] hp_cnt_nx;
    logic                speaker_nx;
    state_t              state;
    state_t              state_nx;

    assign sample_d = map_note(note_in);

    // Stability counter saturates so a long-held note cannot wrap into a false accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample   <= NOTE_NONE;
            stab_cnt <= '0;
            cur_note <= NOTE_NONE;
        end else begin
            sample <= sample_d;
            if (sample_d != sample) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_LAST) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if ((stab_cnt == STAB_LAST) && (sample != cur_note)) begin
                cur_note <= sample;
            end
        end
    end

    note_period_rom #(
        .CLK_HZ(CLK_HZ)
    ) u_rom (
        .note       (cur_note),
        .octave     (octave),
        .half_period(half_period)
    );

    // The ROM output is only consumed at a load/reload, so note and octave
    // changes never shorten the half-period already in flight.
    always_comb begin
        state_nx   = state;
        hp_cnt_nx  = hp_cnt;
        speaker_nx = speaker;
        case (state)
            ST_IDLE: begin
                speaker_nx = 1'b0;
                if (cur_note != NOTE_NONE) begin
                    speaker_nx = 1'b1;
                    hp_cnt_nx  = half_period - 1'b1;
                    state_nx   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (hp_cnt != '0) begin
                    hp_cnt_nx = hp_cnt - 1'b1;
                end else if (cur_note != NOTE_NONE) begin
                    speaker_nx = ~speaker;
                    hp_cnt_nx  = half_period - 1'b1;
                end else begin
                    speaker_nx = 1'b0;
                    state_nx   = ST_IDLE;
                end
            end
            default: begin
                speaker_nx = 1'b0;
                state_nx   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            hp_cnt  <= '0;
            speaker <= 1'b0;
        end else begin
            state   <= state_nx;
            hp_cnt  <= hp_cnt_nx;
            speaker <= speaker_nx;
        end
    end

    assign playing  = (state == ST_PLAY);
    assign note_now = cur_note;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at a scaled-down clock so full tones fit
// in a short run; speaker edge intervals are scored against a queue.
module tb_note_tone_gen;

    localparam int unsigned CLK_HZ     = 100000;
    localparam int unsigned STABLE_CYC = 8;
    localparam int RISE_LAT    = STABLE_CYC + 2;
    localparam int WAIT_BUDGET = 2000;

    // floor(100000 / (2 * f)) for do..si, worked out by hand
    localparam int HP1 = 190;
    localparam int HP2 = 170;
    localparam int HP3 = 151;
    localparam int HP4 = 143;
    localparam int HP5 = 127;
    localparam int HP6 = 113;
    localparam int HP7 = 101;
    localparam int HP1_LOW  = 380;
    localparam int HP1_HIGH = 95;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] note_in = 4'd0;
    logic [1:0] octave = 2'd1;
    logic       speaker;
    logic       playing;
    logic [3:0] note_now;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_last = 0;
    logic spk_last = 1'b0;
    bit   idle_seen = 1'b0;
    int   exp_q[$];

    note_tone_gen #(
        .CLK_HZ    (CLK_HZ),
        .STABLE_CYC(STABLE_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .note_in (note_in),
        .octave  (octave),
        .speaker (speaker),
        .playing (playing),
        .note_now(note_now)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles since the previous speaker edge (or since t_last was marked); -1 on timeout.
    task automatic wait_toggle(output int dt);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        dt   = -1;
        while (!seen && n < WAIT_BUDGET) begin
            @(negedge clk);
            n++;
            if (playing !== 1'b1) idle_seen = 1'b1;
            if (speaker !== spk_last) begin
                seen     = 1'b1;
                spk_last = speaker;
                dt       = cyc - t_last;
                t_last   = cyc;
            end
        end
    endtask

    task automatic expect_toggle(input string tag);
        int          dt;
        logic [31:0] exp;
        wait_toggle(dt);
        exp = 32'hFFFF_FFFF;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        chk(tag, dt, exp);
    endtask

    initial begin
        // reset with note 6 already held: qualification must restart after release
        note_in = 4'd6;
        octave  = 2'd1;
        step(3);
        chk("rst_speaker", speaker, 0);
        chk("rst_playing", playing, 0);
        chk("rst_note_now", note_now, 0);

        rst    = 1'b0;
        t_last = cyc;
        exp_q.push_back(RISE_LAT);
        exp_q.push_back(HP6);
        exp_q.push_back(HP6);
        expect_toggle("n6_rise_latency");
        chk("n6_playing", playing, 1);
        chk("n6_note_now", note_now, 6);
        expect_toggle("n6_half_a");
        expect_toggle("n6_half_b");

        // note 1 low octave, then octave high mid-half
        note_in = 4'd1;
        octave  = 2'd0;
        exp_q.push_back(HP6);
        exp_q.push_back(HP1_LOW);
        expect_toggle("n1_finish_n6_half");
        expect_toggle("n1_low_half");
        step(100);
        octave = 2'd2;
        exp_q.push_back(HP1_LOW);
        exp_q.push_back(HP1_HIGH);
        exp_q.push_back(HP1_HIGH);
        expect_toggle("n1_low_completes");
        expect_toggle("n1_high_half_a");
        expect_toggle("n1_high_half_b");

        // note 5, then release mid-half while speaker is high
        note_in = 4'd5;
        octave  = 2'd1;
        exp_q.push_back(HP1_HIGH);
        exp_q.push_back(HP5);
        exp_q.push_back(HP5);
        expect_toggle("n5_finish_prev");
        expect_toggle("n5_half_a");
        expect_toggle("n5_half_b");
        chk("n5_speaker_high", speaker, 1);
        step(30);
        note_in = 4'd0;
        exp_q.push_back(HP5);
        expect_toggle("n5_release_full_half");
        chk("n5_release_speaker", speaker, 0);
        chk("n5_release_playing", playing, 0);
        chk("n5_release_note_now", note_now, 0);
        step(300);
        chk("idle_speaker_quiet", speaker, 0);
        chk("idle_playing", playing, 0);

        // note 2 to note 7 directly, no pass through idle
        note_in = 4'd2;
        t_last  = cyc;
        exp_q.push_back(RISE_LAT);
        exp_q.push_back(HP2);
        expect_toggle("n2_rise_latency");
        expect_toggle("n2_half");
        note_in   = 4'd7;
        idle_seen = 1'b0;
        exp_q.push_back(HP2);
        exp_q.push_back(HP7);
        exp_q.push_back(HP7);
        expect_toggle("n7_finish_n2_half");
        expect_toggle("n7_first_half");
        expect_toggle("n7_second_half");
        chk("n2_to_n7_no_idle", idle_seen, 0);
        chk("n7_note_now", note_now, 7);

        // codes 9 and 15 are silence
        note_in = 4'd9;
        exp_q.push_back(HP7);
        expect_toggle("code9_stops_tone");
        chk("code9_playing", playing, 0);
        chk("code9_note_now", note_now, 0);
        note_in = 4'd15;
        step(300);
        chk("code15_speaker", speaker, 0);
        chk("code15_playing", playing, 0);
        chk("code15_note_now", note_now, 0);

        // glitch one cycle short of qualification is rejected
        note_in = 4'd3;
        step(STABLE_CYC - 1);
        note_in = 4'd0;
        step(60);
        chk("short_pulse_note_now", note_now, 0);
        chk("short_pulse_speaker", speaker, 0);
        chk("short_pulse_playing", playing, 0);

        // pulse of exactly STABLE_CYC qualifies, then plays one full half and stops
        note_in = 4'd3;
        t_last  = cyc;
        step(STABLE_CYC);
        note_in = 4'd0;
        exp_q.push_back(RISE_LAT);
        exp_q.push_back(HP3);
        expect_toggle("exact_pulse_rise");
        chk("exact_pulse_note_now", note_now, 3);
        expect_toggle("exact_pulse_single_half");
        chk("exact_pulse_playing", playing, 0);

        // asynchronous reset in the middle of a high half-period
        note_in = 4'd4;
        t_last  = cyc;
        exp_q.push_back(RISE_LAT);
        expect_toggle("n4_rise_latency");
        step(20);
        chk("n4_speaker_before_rst", speaker, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_speaker", speaker, 0);
        chk("async_rst_playing", playing, 0);
        chk("async_rst_note_now", note_now, 0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("post_rst_speaker", speaker, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
